output_layer_tx: RTL and testbench

//  Accelerator-side transmitter for the output-layer stream. Accepts result pixels from the

---
 rtl/output_layer_tx_pkg.sv | 11 +
 rtl/output_layer_tx_fifo.sv | 43 ++++
 rtl/output_layer_tx.sv | 57 +++++
 tb/tb_output_layer_tx.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/output_layer_tx_pkg.sv
// output_layer_tx_pkg: shared defaults and width helpers for the output-layer transmitter
package output_layer_tx_pkg;
  localparam int NOUT_DEF            = 3;
  localparam int BIT_WIDTH_DEF       = 8;
  localparam int SPATIAL_DEF         = 25;
  localparam int FIFO_DEPTH_DEF      = 4;
  localparam int FRAME_CNT_WIDTH_DEF = 8;
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/output_layer_tx_fifo.sv
// output_layer_tx_fifo: synchronous FIFO with registered head, cleared memory on reset
module output_layer_tx_fifo
  import output_layer_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [clog2_min1(DEPTH):0] count
);
  localparam int AW = clog2_min1(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/output_layer_tx.sv
// output_layer_tx: buffers conv-core pixels and streams them out with pixel/frame tracking
module output_layer_tx
  import output_layer_tx_pkg::*;
#(
  parameter int Nout               = NOUT_DEF,
  parameter int BIT_WIDTH          = BIT_WIDTH_DEF,
  parameter int OUTPUT_SPATIAL_DIM = SPATIAL_DEF,
  parameter int FIFO_DEPTH         = FIFO_DEPTH_DEF,
  parameter int FRAME_CNT_WIDTH    = FRAME_CNT_WIDTH_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      core_valid,
  input  logic [Nout*BIT_WIDTH-1:0]                 core_data,
  output logic                                      core_rdy,
  output logic                                      output_layer_valid,
  output logic [Nout*BIT_WIDTH-1:0]                 output_layer_data,
  input  logic                                      output_layer_rdy,
  output logic [clog2_min1(OUTPUT_SPATIAL_DIM)-1:0] pixel_idx,
  output logic [FRAME_CNT_WIDTH-1:0]                frame_count,
  output logic                                      frame_done
);
  localparam int W  = Nout * BIT_WIDTH;
  localparam int PW = clog2_min1(OUTPUT_SPATIAL_DIM);
  localparam int CW = clog2_min1(FIFO_DEPTH) + 1;
  logic push, pop, full, empty, last;
  logic [CW-1:0] fifo_count;
  assign core_rdy           = ~rst & ~full;
  assign output_layer_valid = fifo_count != '0;
  assign push               = core_valid & core_rdy;
  assign pop                = ~empty & output_layer_rdy;
  assign last               = pixel_idx == PW'(OUTPUT_SPATIAL_DIM - 1);
  output_layer_tx_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (core_data),
    .rdata (output_layer_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_idx   <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= pop & last;
      if (pop) begin
        pixel_idx <= last ? '0 : pixel_idx + 1'b1;
        if (last) frame_count <= frame_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_output_layer_tx.sv
// tb_output_layer_tx: table, directed and random checks against a queue-based reference model
module tb_output_layer_tx;
  logic clk = 0, rst = 1, core_valid = 0, output_layer_rdy = 0;
  logic [23:0] core_data = '0;
  logic core_rdy, output_layer_valid, frame_done;
  logic [23:0] output_layer_data;
  logic [4:0] pixel_idx;
  logic [7:0] frame_count;
  always #5 clk = ~clk;
  output_layer_tx dut (
    .clk                (clk),
    .rst                (rst),
    .core_valid         (core_valid),
    .core_data          (core_data),
    .core_rdy           (core_rdy),
    .output_layer_valid (output_layer_valid),
    .output_layer_data  (output_layer_data),
    .output_layer_rdy   (output_layer_rdy),
    .pixel_idx          (pixel_idx),
    .frame_count        (frame_count),
    .frame_done         (frame_done)
  );
  int checks = 0, failures = 0;
  logic [23:0] q[$];
  int pix = 0, frames = 0, pulses;
  bit fd = 0;
  bit r_s, cv_s, rdy_s;
  logic [23:0] cd_s;
  typedef struct {
    bit r, cv;
    logic [23:0] cd;
    bit ordy, e_rdy, e_val, e_dv;
    logic [23:0] e_data;
    int e_pix;
  } vec_t;
  vec_t tbl[16];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic drive(input bit r, input bit cv, input logic [23:0] cd, input bit ordy);
    rst = r; core_valid = cv; core_data = cd; output_layer_rdy = ordy;
    r_s = r; cv_s = cv; cd_s = cd; rdy_s = ordy;
    #2;
  endtask
  task automatic chk_model;
    chk("core_rdy", core_rdy, !r_s && q.size() < 4);
    chk("valid", output_layer_valid, q.size() != 0);
    if (q.size() != 0) chk("data", output_layer_data, q[0]);
    chk("pixel_idx", pixel_idx, pix);
    chk("frame_count", frame_count, frames);
    chk("frame_done", frame_done, fd);
    chk("fifo_count", dut.fifo_count, q.size());
  endtask
  task automatic tick;
    bit push, pop, wrap;
    push = cv_s && !r_s && q.size() < 4;
    pop  = q.size() != 0 && rdy_s;
    @(posedge clk);
    if (r_s) begin
      q.delete(); pix = 0; frames = 0; fd = 0;
    end else begin
      wrap = pop && pix == 24;
      fd = wrap;
      if (pop) begin
        void'(q.pop_front());
        pix = wrap ? 0 : pix + 1;
        if (wrap) frames = (frames + 1) % 256;
      end
      if (push) q.push_back(cd_s);
    end
    #1;
  endtask
  task automatic cyc(input bit r, input bit cv, input logic [23:0] cd, input bit ordy);
    drive(r, cv, cd, ordy);
    chk_model();
    tick();
  endtask
  initial begin
    tbl[0]  = '{1, 1, 24'hAA, 0, 0, 0, 1, 24'h0, 0};
    tbl[1]  = '{1, 1, 24'hAA, 0, 0, 0, 1, 24'h0, 0};
    tbl[2]  = '{1, 1, 24'hAA, 0, 0, 0, 1, 24'h0, 0};
    tbl[3]  = '{0, 1, 24'h030201, 1, 1, 0, 0, 24'h0, 0};
    tbl[4]  = '{0, 0, 24'h0, 1, 1, 1, 1, 24'h030201, 0};
    tbl[5]  = '{0, 0, 24'h0, 0, 1, 0, 0, 24'h0, 1};
    tbl[6]  = '{0, 1, 24'h1, 0, 1, 0, 0, 24'h0, 1};
    tbl[7]  = '{0, 1, 24'h2, 0, 1, 1, 1, 24'h1, 1};
    tbl[8]  = '{0, 1, 24'h3, 0, 1, 1, 1, 24'h1, 1};
    tbl[9]  = '{0, 1, 24'h4, 0, 1, 1, 1, 24'h1, 1};
    tbl[10] = '{0, 1, 24'h5, 0, 0, 1, 1, 24'h1, 1};
    tbl[11] = '{0, 0, 24'h0, 1, 0, 1, 1, 24'h1, 1};
    tbl[12] = '{0, 0, 24'h0, 1, 1, 1, 1, 24'h2, 2};
    tbl[13] = '{0, 0, 24'h0, 1, 1, 1, 1, 24'h3, 3};
    tbl[14] = '{0, 0, 24'h0, 1, 1, 1, 1, 24'h4, 4};
    tbl[15] = '{0, 0, 24'h0, 0, 1, 0, 0, 24'h0, 5};
    drive(1, 1, 24'hAA, 0); tick();
    drive(1, 1, 24'hAA, 0); tick();
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r, tbl[i].cv, tbl[i].cd, tbl[i].ordy);
      chk($sformatf("tbl%0d_rdy", i), core_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_valid", i), output_layer_valid, tbl[i].e_val);
      if (tbl[i].e_dv) chk($sformatf("tbl%0d_data", i), output_layer_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_pix", i), pixel_idx, tbl[i].e_pix);
      chk_model();
      tick();
    end
    chk("tbl_frame_count", frame_count, 0);
    // two entries held, then push and pop together for several cycles
    cyc(0, 1, 24'h10, 0);
    cyc(0, 1, 24'h11, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 24'h20 + 24'(i), 1);
    chk("simul_count", dut.fifo_count, 2);
    repeat (4) cyc(0, 0, 24'h0, 1);
    cyc(1, 0, 24'h0, 0);
    for (int f = 1; f <= 2; f++) begin
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
        cyc(0, 1, 24'(100 * f + i), 1);
        pulses += int'(frame_done);
      end
      repeat (3) begin
        cyc(0, 0, 24'h0, 1);
        pulses += int'(frame_done);
      end
      chk($sformatf("frame%0d_pulses", f), pulses, 1);
      chk($sformatf("frame%0d_count", f), frame_count, f);
      chk($sformatf("frame%0d_pix", f), pixel_idx, 0);
    end
    cyc(1, 0, 24'h0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 24'h50 + 24'(i), 1);
    repeat (2) cyc(0, 0, 24'h0, 1);
    chk("mid_pix7", pixel_idx, 7);
    for (int i = 0; i < 3; i++) cyc(0, 1, 24'h60 + 24'(i), 0);
    chk("mid_count3", dut.fifo_count, 3);
    cyc(1, 0, 24'h0, 1);
    chk("mid_rst_valid", output_layer_valid, 0);
    chk("mid_rst_pix", pixel_idx, 0);
    repeat (2) cyc(0, 0, 24'h0, 1);
    cyc(0, 1, 24'h77, 1);
    chk("mid_new_data", output_layer_data, 24'h77);
    cyc(0, 0, 24'h0, 1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 2) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
